// File: rtl/stage3_pkg.sv
// Shared types and constants for the writeback stage (pipe_stage3_wb and its FIFO).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage3_pkg;

    // Default "no center matched" sentinel; equals the vector count.
    localparam int N_SENTINEL      = 4096;
    // Default capacity of the center table.
    localparam int MAX_CENTERS_DEF = 256;
    // Field width inside a buffered entry. Operand and address parameters of the
    // top must stay below this; unused upper bits are constant zero.
    localparam int ENTRY_W         = 32;
    // Upstream stage number during which match results are presented.
    localparam logic [2:0] RESULT_STAGE = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } wb_state_e;

    typedef struct packed {
        logic [ENTRY_W-1:0] addr;
        logic [ENTRY_W-1:0] resolved_id;
        logic [ENTRY_W-1:0] dnorm;
    } wb_entry_t;

endpackage

// File: rtl/stage3_fifo.sv
// Synchronous FIFO of wb_entry_t with a registered head (first-word fall-through).
// Latency: an entry pushed at edge k is visible on head from cycle k+1.
// Backpressure: holds DEPTH-1 entries; pushes while full are refused, even alongside a pop.
//
// Ports: clk, rst (async, active-high), push/push_data, pop, head, full, empty, count.
module stage3_fifo
    import stage3_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry no wrap bit, so one slot always stays free: the occupancy
    // is the plain modular pointer difference and tops out at DEPTH-1.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == PTR_W'(DEPTH - 1));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_stage3_wb.sv
// Writeback stage: resolves "no match" sentinels into new center ids, buffers results, writes them to SRAM.
// Latency: entry accepted at edge k drives wr_valid_o from cycle k+1; one entry per cycle with ready high.
// Backpressure: stall_o when the FIFO holds DEPTH-1 entries or while draining; wr_valid_o never depends on wr_ready_i.
//
// Ports: CLK_i/RST_i (async active-high); upstream stage_i, finished_i, valid_i, center_id_i, dnorm_i, stall_o;
// SRAM wr_valid_o/wr_ready_i/wr_addr_o/wr_data_o; status center_cnt_o, overflow_o (sticky), done_o (level).
// Optional macro PIPE_STAGE3_PERF_EN adds stall_cycles_o (COLLECT cycles stalled) and drop_cnt_o (saturating).
module pipe_stage3_wb
    import stage3_pkg::*;
#(
    parameter int N           = N_SENTINEL,
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 12,
    parameter int MAX_CENTERS = MAX_CENTERS_DEF
) (
    input  logic                 CLK_i,
    input  logic                 RST_i,
    input  logic [2:0]           stage_i,
    input  logic                 finished_i,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     center_id_i,
    input  logic [WIDTH-1:0]     dnorm_i,
    output logic                 stall_o,
    output logic                 wr_valid_o,
    input  logic                 wr_ready_i,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [2*WIDTH-1:0]   wr_data_o,
    output logic [WIDTH-1:0]     center_cnt_o,
    output logic                 overflow_o,
    output logic                 done_o
`ifdef PIPE_STAGE3_PERF_EN
    ,
    output logic [31:0]          stall_cycles_o,
    output logic [15:0]          drop_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH);

    wb_state_e         state;
    wb_state_e         state_nxt;
    logic [ADDR_W-1:0] vec_idx;
    logic [WIDTH-1:0]  center_cnt;
    logic              overflow;

    wb_entry_t         push_entry;
    wb_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic              in_stage;
    logic              open;
    logic              accept;
    logic              is_sentinel;
    logic              room;
    logic              wr_fire;
    logic              unused_head_bits;

    assign in_stage    = (stage_i == RESULT_STAGE);
    // IDLE also accepts: the first stage-6 cycle may already carry a result.
    assign open        = (state == COLLECT) || ((state == IDLE) && in_stage);
    assign accept      = open && valid_i && in_stage && !fifo_full;
    assign is_sentinel = (center_id_i == WIDTH'(N));
    assign room        = (center_cnt < WIDTH'(MAX_CENTERS));
    assign wr_fire     = !fifo_empty && wr_ready_i;

    // Sentinel resolution. When the table is full the sentinel passes through
    // unchanged, which is exactly center_id_i in that branch.
    always_comb begin
        push_entry       = '0;
        push_entry.addr  = ENTRY_W'(vec_idx);
        push_entry.dnorm = ENTRY_W'(dnorm_i);
        if (is_sentinel && room) begin
            push_entry.resolved_id = ENTRY_W'(center_cnt);
        end else begin
            push_entry.resolved_id = ENTRY_W'(center_id_i);
        end
    end

    stage3_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK_i),
        .rst       (RST_i),
        .push      (accept),
        .push_data (push_entry),
        .pop       (wr_fire),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state      <= IDLE;
            vec_idx    <= '0;
            center_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                vec_idx <= vec_idx + ADDR_W'(1);
                if (is_sentinel) begin
                    if (room) begin
                        center_cnt <= center_cnt + WIDTH'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (finished_i) begin
                    state_nxt = DRAIN;
                end else if (in_stage) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (finished_i) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave on the edge that retires the last entry so done_o
                // rises the cycle right after the final handshake.
                if (fifo_empty || ((fifo_count == CNT_W'(1)) && wr_fire)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign stall_o      = (fifo_count >= CNT_W'(DEPTH - 1)) || (state == DRAIN);
    assign wr_valid_o   = !fifo_empty;
    assign wr_addr_o    = head.addr[ADDR_W-1:0];
    assign wr_data_o    = {head.resolved_id[WIDTH-1:0], head.dnorm[WIDTH-1:0]};
    assign center_cnt_o = center_cnt;
    assign overflow_o   = overflow;
    assign done_o       = (state == DONE);

    // Upper entry bits are always zero; fold them so they are not left dangling.
    assign unused_head_bits = ^{head.addr[ENTRY_W-1:ADDR_W],
                                head.resolved_id[ENTRY_W-1:WIDTH],
                                head.dnorm[ENTRY_W-1:WIDTH]};

`ifdef PIPE_STAGE3_PERF_EN
    logic        drop;
    logic [31:0] stall_cycles;
    logic [15:0] drop_cnt;

    assign drop = open && valid_i && in_stage && fifo_full;

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            stall_cycles <= '0;
            drop_cnt     <= '0;
        end else begin
            if ((state == COLLECT) && stall_o) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles;
    assign drop_cnt_o     = drop_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage3_wb.sv
// Directed bench for pipe_stage3_wb: a default instance and a small one (MAX_CENTERS=2, ADDR_W=2) share stimulus.
// Inputs change and outputs are sampled 1 time unit after the rising edge; handshakes are logged on the falling edge.
// Each scenario task carries its own inline checks against hand-computed values.
module tb_pipe_stage3_wb;

    localparam int NS = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  stage;
    logic        finished;
    logic        valid;
    logic [15:0] center_id;
    logic [15:0] dnorm;
    logic        wr_ready;

    logic        a_stall, a_wr_valid, a_overflow, a_done;
    logic [11:0] a_wr_addr;
    logic [31:0] a_wr_data;
    logic [15:0] a_center_cnt;
    logic        b_stall, b_wr_valid, b_overflow, b_done;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [15:0] b_center_cnt;
`ifdef PIPE_STAGE3_PERF_EN
    logic [31:0] a_stall_cycles, b_stall_cycles;
    logic [15:0] a_drop_cnt, b_drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] qa_addr[$];
    logic [31:0] qa_data[$];
    logic [1:0]  qb_addr[$];
    logic [31:0] qb_data[$];

    always #5 clk = ~clk;

    pipe_stage3_wb dut_a (
        .CLK_i(clk), .RST_i(rst), .stage_i(stage), .finished_i(finished), .valid_i(valid),
        .center_id_i(center_id), .dnorm_i(dnorm), .stall_o(a_stall), .wr_valid_o(a_wr_valid),
        .wr_ready_i(wr_ready), .wr_addr_o(a_wr_addr), .wr_data_o(a_wr_data),
        .center_cnt_o(a_center_cnt), .overflow_o(a_overflow), .done_o(a_done)
`ifdef PIPE_STAGE3_PERF_EN
        , .stall_cycles_o(a_stall_cycles), .drop_cnt_o(a_drop_cnt)
`endif
    );

    pipe_stage3_wb #(.MAX_CENTERS(2), .ADDR_W(2)) dut_b (
        .CLK_i(clk), .RST_i(rst), .stage_i(stage), .finished_i(finished), .valid_i(valid),
        .center_id_i(center_id), .dnorm_i(dnorm), .stall_o(b_stall), .wr_valid_o(b_wr_valid),
        .wr_ready_i(wr_ready), .wr_addr_o(b_wr_addr), .wr_data_o(b_wr_data),
        .center_cnt_o(b_center_cnt), .overflow_o(b_overflow), .done_o(b_done)
`ifdef PIPE_STAGE3_PERF_EN
        , .stall_cycles_o(b_stall_cycles), .drop_cnt_o(b_drop_cnt)
`endif
    );

    // Valid and ready are stable from 1 unit after the rising edge, so what is
    // seen here is exactly what the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_wr_valid && wr_ready) begin
                qa_addr.push_back(a_wr_addr);
                qa_data.push_back(a_wr_data);
            end
            if (b_wr_valid && wr_ready) begin
                qb_addr.push_back(b_wr_addr);
                qb_data.push_back(b_wr_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; stage = 3'd0; finished = 1'b0; valid = 1'b0;
        center_id = 16'd0; dnorm = 16'd0; wr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (a_wr_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_valid: got %0h need 0", a_wr_valid); end
        n_checks++; if (a_stall !== 1'b0)       begin n_fail++; $display("FAIL reset_stall: got %0h need 0", a_stall); end
        n_checks++; if (a_wr_addr !== 12'd0)    begin n_fail++; $display("FAIL reset_addr: got %0h need 0", a_wr_addr); end
        n_checks++; if (a_wr_data !== 32'd0)    begin n_fail++; $display("FAIL reset_data: got %0h need 0", a_wr_data); end
        n_checks++; if (a_center_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_center_cnt: got %0h need 0", a_center_cnt); end
        n_checks++; if (a_overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow: got %0h need 0", a_overflow); end
        n_checks++; if (a_done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %0h need 0", a_done); end
`ifdef PIPE_STAGE3_PERF_EN
        n_checks++; if (a_drop_cnt !== 16'd0)   begin n_fail++; $display("FAIL reset_drop_cnt: got %0h need 0", a_drop_cnt); end
        n_checks++; if (a_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cycles: got %0h need 0", a_stall_cycles); end
`endif
    endtask

    task automatic test_basic();
        logic [15:0] ids[3];
        logic [15:0] dn[3];
        logic [31:0] exp_data[3];
        ids = '{16'd5, 16'(NS), 16'd7};
        dn  = '{16'h1111, 16'h2222, 16'h3333};
        exp_data = '{32'h0005_1111, 32'h0000_2222, 32'h0007_3333};
        apply_reset();
        stage = 3'd6; wr_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; center_id = ids[i]; dnorm = dn[i];
            tick();
            if (i == 0) begin
                n_checks++; if (a_wr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid: got %0h need 1", a_wr_valid); end
                n_checks++; if (a_wr_data !== 32'h0005_1111) begin n_fail++; $display("FAIL basic_latency_data: got %0h need 00051111", a_wr_data); end
            end
            n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall: got %0h need 0", a_stall); end
        end
        valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (qa_addr.size() != 3) begin n_fail++; $display("FAIL basic_write_count: got %0d need 3", qa_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < qa_addr.size()) begin
                n_checks++; if (qa_addr[i] !== 12'(i)) begin n_fail++; $display("FAIL basic_addr%0d: got %0h need %0h", i, qa_addr[i], i); end
                n_checks++; if (qa_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL basic_data%0d: got %0h need %0h", i, qa_data[i], exp_data[i]); end
            end
        end
        n_checks++; if (a_center_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_center_cnt: got %0d need 1", a_center_cnt); end
        n_checks++; if (a_wr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %0h need 0", a_wr_valid); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        stage = 3'd6; wr_ready = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            valid = 1'b1; center_id = 16'(10 + i); dnorm = 16'(16'h0100 + i);
            tick();
            if (i == 5) begin
                n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL bp_stall_at6: got %0h need 0", a_stall); end
            end
        end
        n_checks++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL bp_stall_at7: got %0h need 1", a_stall); end
        // 8th entry arrives while full, alongside a pop: it must still be refused.
        center_id = 16'd17; dnorm = 16'h0107; wr_ready = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (qa_addr.size() != 7) begin n_fail++; $display("FAIL bp_write_count: got %0d need 7", qa_addr.size()); end
        for (int i = 0; i < 7; i++) begin
            if (i < qa_addr.size()) begin
                n_checks++; if (qa_addr[i] !== 12'(i)) begin n_fail++; $display("FAIL bp_addr%0d: got %0h need %0h", i, qa_addr[i], i); end
                n_checks++; if (qa_data[i] !== {16'(10 + i), 16'(16'h0100 + i)}) begin n_fail++; $display("FAIL bp_data%0d: got %0h need %0h", i, qa_data[i], {16'(10 + i), 16'(16'h0100 + i)}); end
            end
        end
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL bp_stall_after: got %0h need 0", a_stall); end
`ifdef PIPE_STAGE3_PERF_EN
        n_checks++; if (a_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_drop_cnt: got %0d need 1", a_drop_cnt); end
`endif
    endtask

    task automatic test_overflow();
        logic [31:0] exp_b[3];
        exp_b = '{32'h0000_00a0, 32'h0001_00a1, 32'h1000_00a2};
        apply_reset();
        stage = 3'd6; wr_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; center_id = 16'(NS); dnorm = 16'(16'h00a0 + i);
            tick();
            if (i == 0) begin
                n_checks++; if (b_center_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_cnt_after1: got %0d need 1", b_center_cnt); end
            end
            if (i == 1) begin
                n_checks++; if (b_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %0h need 0", b_overflow); end
            end
        end
        valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (b_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0h need 1", b_overflow); end
        n_checks++; if (b_center_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_cnt: got %0d need 2", b_center_cnt); end
        n_checks++; if (a_center_cnt !== 16'd3) begin n_fail++; $display("FAIL ovf_big_cnt: got %0d need 3", a_center_cnt); end
        n_checks++; if (a_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_big_flag: got %0h need 0", a_overflow); end
        n_checks++; if (qb_data.size() != 3) begin n_fail++; $display("FAIL ovf_write_count: got %0d need 3", qb_data.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < qb_data.size()) begin
                n_checks++; if (qb_data[i] !== exp_b[i]) begin n_fail++; $display("FAIL ovf_data%0d: got %0h need %0h", i, qb_data[i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_done();
        apply_reset();
        stage = 3'd6; wr_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; center_id = 16'(i + 1); dnorm = 16'h0c00;
            finished = (i == 3);
            tick();
        end
        valid = 1'b0;
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %0h need 0", a_done); end
        n_checks++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL done_drain_stall: got %0h need 1", a_stall); end
        for (int c = 0; c < 16; c++) begin
            wr_ready = (c % 2 == 0);
            if (c == 1) finished = 1'b0;
            tick();
            n_checks++;
            if (a_done !== (qa_addr.size() >= 4)) begin
                n_fail++; $display("FAIL done_level_c%0d: got %0h need %0h (writes %0d)", c, a_done, (qa_addr.size() >= 4), qa_addr.size());
            end
        end
        n_checks++; if (qa_addr.size() != 4) begin n_fail++; $display("FAIL done_write_count: got %0d need 4", qa_addr.size()); end
        if (qa_addr.size() == 4) begin
            n_checks++; if (qa_addr[3] !== 12'd3) begin n_fail++; $display("FAIL done_last_addr: got %0h need 3", qa_addr[3]); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        stage = 3'd6; wr_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; center_id = 16'(NS); dnorm = 16'h0111;
            tick();
        end
        valid = 1'b0;
        n_checks++; if (a_wr_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_queued: got %0h need 1", a_wr_valid); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (a_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_drop: got %0h need 0", a_wr_valid); end
        n_checks++; if (a_center_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d need 0", a_center_cnt); end
        tick();
        rst = 1'b0; wr_ready = 1'b1;
        qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
        tick();
        valid = 1'b1; center_id = 16'd9; dnorm = 16'h0abc;
        tick();
        valid = 1'b0;
        n_checks++; if (a_wr_addr !== 12'd0) begin n_fail++; $display("FAIL rmid_addr: got %0h need 0", a_wr_addr); end
        n_checks++; if (a_wr_data !== 32'h0009_0abc) begin n_fail++; $display("FAIL rmid_data: got %0h need 00090abc", a_wr_data); end
        tick();
        tick();
        n_checks++; if (qa_addr.size() != 1) begin n_fail++; $display("FAIL rmid_write_count: got %0d need 1", qa_addr.size()); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_addr[5];
        exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        stage = 3'd6; wr_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1;
            if (i == 2) begin
                stage = 3'd3; center_id = 16'd99; dnorm = 16'h0999;
            end else begin
                stage = 3'd6; center_id = 16'(20 + i - (i > 2 ? 1 : 0)); dnorm = 16'h0200;
            end
            tick();
        end
        valid = 1'b0; stage = 3'd6;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (qb_addr.size() != 5) begin n_fail++; $display("FAIL wrap_write_count: got %0d need 5", qb_addr.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < qb_addr.size()) begin
                n_checks++; if (qb_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr%0d: got %0d need %0d", i, qb_addr[i], exp_addr[i]); end
                n_checks++; if (qb_data[i] !== {16'(20 + i), 16'h0200}) begin n_fail++; $display("FAIL wrap_data%0d: got %0h need %0h", i, qb_data[i], {16'(20 + i), 16'h0200}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_done();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
